pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the five-stage core. Drives the per-stage stall vector that gates the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves simultaneous stall requests by stage priority.
- Sequences exception-entry and ERET flushes: registered flush pulse plus redirect PC.
- Provides a consecutive-stall watchdog so hung multi-cycle units are detected.

Parameters:
- FLUSH_CYCLES, 1, number of cycles flush stays asserted per redirect event (1..15).
- STALL_LIMIT, 1023, consecutive stalled cycles before stall_timeout fires (1..65535).
- CNT_W, 16, width of the stall watchdog counter and of the perf counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_if  in  1  fetch stage stall request
- stallreq_id  in  1  decode stage stall request
- stallreq_ex  in  1  execute stage stall request (e.g. multi-cycle div)
- stallreq_mem  in  1  memory stage stall request
- excp_valid  in  1  exception committed in MEM this cycle
- excp_vector  in  32  handler address for excp_valid
- eret_valid  in  1  ERET committed in MEM this cycle
- eret_pc  in  32  return address for eret_valid
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
- flush  out  1  clear all pipeline registers to bubble
- new_pc  out  32  redirect target, valid while flush=1
- stall_timeout  out  1  one-cycle pulse on watchdog expiry
- busy  out  1  high while FSM not in RUN

Behaviour:
- Reset values: stall=0, flush=0, new_pc=0, stall_timeout=0, busy=0; FSM=RUN; all counters=0.
- Stall encoding is combinational from requests, same cycle. Highest requesting stage wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 0
- stall is forced to 0 whenever state != RUN.
- FSM states: RUN, FLUSH.
- RUN:
  - excp_valid sampled high -> next cycle FLUSH, flush=1, new_pc<=excp_vector.
  - Otherwise eret_valid high -> same, with new_pc<=eret_pc.
  - excp_valid has priority over eret_valid when both are high.
  - In the sampling cycle itself, stall follows the requests normally. Latency from event to flush is 1 cycle.
- FLUSH:
  - flush=1, new_pc held, busy=1 for FLUSH_CYCLES cycles, tracked by an internal down-counter.
  - Then returns to RUN: flush=0, new_pc holds its last value.
  - excp_valid and eret_valid are ignored in FLUSH; they originate from squashed instructions.
- flush and new_pc are registered. flush deasserts in the same cycle the FSM re-enters RUN.
- Watchdog:
  - Counter increments each cycle stall != 0 and clears on any cycle stall == 0. It saturates at STALL_LIMIT.
  - stall_timeout pulses for the single cycle the counter transitions to STALL_LIMIT.
  - The counter does not re-pulse until it has been cleared.
- rst asserted mid-FLUSH: next edge returns FSM to RUN with all outputs at reset values. The pending redirect is discarded.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds output perf_stall_cycles (CNT_W) and output perf_flush_events (CNT_W).
  - perf_stall_cycles counts every cycle with stall != 0.
  - perf_flush_events counts every RUN->FLUSH transition.
  - Both wrap modulo 2^CNT_W and clear on rst.
- Not defined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Requests and stall vector: stallreq_id=1 with stallreq_ex=1 in the same cycle -> stall=6'b001111 in that cycle. Drop both -> stall=0 in the next cycle.
- Exception entry: excp_valid=1, excp_vector=0x00000020 with FLUSH_CYCLES=1 -> next cycle flush=1, new_pc=0x00000020, busy=1, stall=0. Cycle after -> flush=0, busy=0.
- Simultaneous excp/eret: excp_valid=1 (vector 0x20) and eret_valid=1 (eret_pc 0x400) together -> new_pc=0x20. Repeat with FLUSH_CYCLES=3 and eret_valid pulsed during FLUSH -> flush high exactly 3 cycles, new_pc unchanged.
- Watchdog: STALL_LIMIT=8, stallreq_mem held 20 cycles -> stall_timeout pulses once on the 8th stalled cycle. Drop the request 1 cycle, re-stall 8 cycles -> a second pulse.
- Reset mid-operation: rst asserted in the 2nd cycle of a 3-cycle FLUSH -> following cycle flush=0, new_pc=0, busy=0, FSM in RUN.
- With PIPE_CTRL_PERF_EN: 5 stalled cycles plus 2 exceptions -> perf_stall_cycles=5, perf_flush_events=2. Both read 0 after rst.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline stall/flush sequencer with stall watchdog; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_LIMIT  = 1023,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  logic [31:0]      excp_vector,
  input  logic             eret_valid,
  input  logic [31:0]      eret_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             stall_timeout,
  output logic             busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flush_events
`endif
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [5:0]       req_stall;
  logic             redirect;
  // state, flush down-counter, redirect target and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pc_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      wd_q    <= wd_d;
    end
  end
  // next state: a committed exception (over ERET) in RUN opens a FLUSH_CYCLES-long flush window
  always_comb begin
    req_stall = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
                stallreq_id  ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    redirect  = (state_q == RUN) && (excp_valid || eret_valid);
    state_d   = (state_q == RUN) ? (redirect ? FLUSH : RUN) : ((fcnt_q == 4'd0) ? RUN : FLUSH);
    fcnt_d    = (state_q == RUN) ? 4'(FLUSH_CYCLES - 1) : fcnt_q - 4'd1;
    pc_d      = redirect ? (excp_valid ? excp_vector : eret_pc) : pc_q;
    wd_d      = (stall == 6'd0) ? '0 : ((wd_q == CNT_W'(STALL_LIMIT)) ? wd_q : wd_q + CNT_W'(1));
  end
  // outputs: stalls only pass through in RUN; timeout fires on the cycle the watchdog reaches its limit
  always_comb begin
    stall         = (state_q == RUN) ? req_stall : 6'd0;
    flush         = (state_q == FLUSH);
    busy          = (state_q != RUN);
    new_pc        = pc_q;
    stall_timeout = (stall != 6'd0) && (wd_q == CNT_W'(STALL_LIMIT - 1));
  end
`ifdef PIPE_CTRL_PERF_EN
  // free-running wrap-around performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + CNT_W'(stall != 6'd0);
      perf_flush_events <= perf_flush_events + CNT_W'(redirect);
    end
  end
`endif
endmodule
